corescore_rst_seq: RTL and testbench
====================================

// Module: corescore_rst_seq
// PURPOSE
//  Parametrised clock-lock supervisor and reset sequencer for MMCM/PLL-based clock generators.
//  - Owns the MMCM reset.
//  - Watches LOCKED and retries lock on timeout.
//  - Releases CHANNELS reset outputs in staggered order.
//  - Re-asserts all resets on lock loss.
//  Runs on the free-running board clock; sits beside the MMCM in each board's clock_gen.
// PARAMETERS
//  CHANNELS        3    number of o_rst outputs, >=1
//  SYNC_STAGES     2    i_locked synchroniser depth, >=2
//  MMCM_RST_CYCLES 8    o_mmcm_rst pulse width in cycles, >=1
//  LOCK_TIMEOUT    64   cycles in WAIT_LOCK without lock before re-pulsing MMCM reset, >=1
//  HOLD_CYCLES     16   consecutive locked cycles required before first release, >=1
//  STAGGER         4    cycles between release of channel k and channel k+1, >=1
// PORTS
//  i_clk       in   1         free-running board clock; all logic on posedge
//  i_rst       in   1         synchronous active-high reset
//  i_locked    in   1         MMCM LOCKED, asynchronous to i_clk
//  o_mmcm_rst  out  1         reset to MMCM RST pin
//  o_rst       out  CHANNELS  per-domain active-high resets; bit 0 released first
//  o_ready     out  1         high when all channels are released
//  o_loss_cnt  out  8         lock-loss event count; present only with CORESCORE_RST_LOSS_CNT_EN
// BEHAVIOUR
//  Reset (i_rst=1), applied at the next edge:
//   - state=MMCM_RST, counter=0, synchroniser=0.
//   - o_mmcm_rst=1, o_rst=all ones, o_ready=0, o_loss_cnt=0.
//  locked_s: i_locked after SYNC_STAGES flops. Only locked_s is used by the FSM.
//  Single shared counter, width $clog2(max of cycle parameters, STAGGER*CHANNELS)+1. Cleared on every state change.
//  FSM:
//   MMCM_RST : o_mmcm_rst=1 for exactly MMCM_RST_CYCLES cycles (counted from i_rst low or from entry) -> WAIT_LOCK.
//   WAIT_LOCK: o_mmcm_rst=0.
//     - locked_s=1 -> HOLD.
//     - LOCK_TIMEOUT cycles elapsed with locked_s=0 -> MMCM_RST.
//   HOLD     : counts consecutive locked_s=1.
//     - locked_s=0 -> WAIT_LOCK. Timeout restarts; no loss count.
//     - After HOLD_CYCLES cycles -> RELEASE; o_rst[0] clears on that same edge.
//   RELEASE  : o_rst[k] clears exactly k*STAGGER cycles after o_rst[0].
//     - o_ready rises on the same edge o_rst[CHANNELS-1] clears; -> RUN.
//     - CHANNELS=1: goes straight to RUN, with o_ready rising on the o_rst[0] edge.
//   RUN      : steady state. o_rst=0, o_ready=1.
//  Lock loss (locked_s=0 in RELEASE or RUN):
//   - Next edge: o_rst=all ones, o_ready=0, state=WAIT_LOCK. o_mmcm_rst is not pulsed unless timeout follows.
//   - Counted as one loss event.
//  Released resets never re-release out of order.
//   - A channel, once re-asserted, is only cleared again via a full HOLD -> RELEASE sequence.
//  i_rst in any state, including mid-RELEASE: immediate return to reset values at the next edge.
//  Outputs are registered; no combinational path from i_locked or i_rst to any output.
// CONFIGURATION
//  CORESCORE_RST_LOSS_CNT_EN defined:
//   - o_loss_cnt port exists.
//   - Increments by 1 per lock-loss event in RELEASE/RUN; saturates at 255; cleared only by i_rst.
//  CORESCORE_RST_LOSS_CNT_EN undefined:
//   - Port and counter are absent; all other behaviour is identical.
// TESTING (defaults: CHANNELS=3, SYNC_STAGES=2, MMCM_RST_CYCLES=8, LOCK_TIMEOUT=64, HOLD_CYCLES=16, STAGGER=4)
//  1 i_locked=1 throughout, i_rst falls
//    -> o_mmcm_rst high 8 cycles.
//    -> o_rst[0] clears after 16 locked cycles in HOLD; o_rst[1] 4 cycles later; o_rst[2] and o_ready 8 cycles later.
//  2 i_locked=0 forever
//    -> o_mmcm_rst pulses 8 cycles high, then 64 low, repeating.
//    -> o_rst stays 3'b111; o_ready stays 0.
//  3 In RUN, i_locked low 5 cycles, then high
//    -> o_rst=3'b111 and o_ready=0 on the edge after locked_s falls.
//    -> no o_mmcm_rst pulse.
//    -> the full 16+4+4 release sequence repeats.
//    -> o_loss_cnt=1.
//  4 i_locked drops 1 cycle at HOLD count 10
//    -> HOLD restarts; o_rst[0] clears 16 locked cycles after relock; o_loss_cnt unchanged.
//  5 i_rst=1 for 1 cycle when o_rst=3'b110
//    -> next edge: o_rst=3'b111, o_mmcm_rst=1, o_ready=0.
//    -> the full sequence replays.
//  6 CORESCORE_RST_LOSS_CNT_EN defined, 300 loss events
//    -> o_loss_cnt=255 and holds; i_rst -> 0.

Source files
------------

// File: rtl/corescore_rst_seq.sv
// -----------------------------------------------------------------------------
// corescore_rst_seq
// Clock-lock supervisor and reset sequencer for MMCM/PLL clock generators.
// Pulses the MMCM reset, waits for LOCKED (retrying on timeout), requires a
// stable lock window, then releases CHANNELS reset outputs in staggered order.
// Any lock loss after release re-asserts every channel reset at once.
//
// Optional feature macro: CORESCORE_RST_LOSS_CNT_EN
//   defined   -> o_loss_cnt port and saturating 8-bit lock-loss counter exist
//   undefined -> port and counter are absent, all other behaviour identical
//
// All outputs come straight from flops; i_rst is a synchronous active-high
// reset sampled on the rising edge of i_clk.
// -----------------------------------------------------------------------------
module corescore_rst_seq #(
    parameter int CHANNELS        = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int MMCM_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT    = 64,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER         = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_locked,
    output logic                o_mmcm_rst,
    output logic [CHANNELS-1:0] o_rst,
    output logic                o_ready
`ifdef CORESCORE_RST_LOSS_CNT_EN
    ,
    output logic [7:0]          o_loss_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Shared counter sizing: wide enough for the longest interval any state
    // has to measure, including the full stagger span of the release phase.
    // -------------------------------------------------------------------------
    localparam int MAX_AB   = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ABC  = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
    localparam int SPAN     = STAGGER * CHANNELS;
    localparam int MAX_ALL  = (MAX_ABC > SPAN) ? MAX_ABC : SPAN;
    localparam int CNT_W    = $clog2(MAX_ALL) + 1;

    // Terminal counts: a state with an N-cycle interval leaves when the
    // counter holds N-1, so the exit edge is the N-th edge spent in it.
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((CHANNELS - 1) * STAGGER);

    localparam logic [CHANNELS-1:0] RST_ALL   = {CHANNELS{1'b1}};

    typedef enum logic [2:0] {
        ST_MMCM_RST = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and next-state signals
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [CNT_W-1:0]       cnt_inc_s;

    logic                   mmcm_rst_r;
    logic                   mmcm_rst_nxt_s;
    logic [CHANNELS-1:0]    rst_r;
    logic [CHANNELS-1:0]    rst_nxt_s;
    logic                   ready_r;
    logic                   ready_nxt_s;

    // Set for one cycle when lock is lost after release has begun.
    logic                   loss_evt_s;

    // i_locked is asynchronous to i_clk; only the last synchroniser stage is
    // ever looked at by the sequencer.
    assign locked_s  = sync_r[SYNC_STAGES-1];
    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Bring the asynchronous LOCKED signal into the i_clk domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_locked};
        end
    end

    // State, shared counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_MMCM_RST;
            cnt_r      <= CNT_ZERO;
            mmcm_rst_r <= 1'b1;
            rst_r      <= RST_ALL;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            mmcm_rst_r <= mmcm_rst_nxt_s;
            rst_r      <= rst_nxt_s;
            ready_r    <= ready_nxt_s;
        end
    end

    // Next-state, counter and next-output decode for the sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        mmcm_rst_nxt_s = mmcm_rst_r;
        rst_nxt_s      = rst_r;
        ready_nxt_s    = ready_r;
        loss_evt_s     = 1'b0;

        case (state_r)
            // Hold the MMCM in reset for a fixed pulse width, LOCKED ignored.
            ST_MMCM_RST: begin
                rst_nxt_s   = RST_ALL;
                ready_nxt_s = 1'b0;
                if (cnt_r == MMCM_LAST) begin
                    state_nxt_s    = ST_WAIT_LOCK;
                    cnt_nxt_s      = CNT_ZERO;
                    mmcm_rst_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s      = cnt_inc_s;
                    mmcm_rst_nxt_s = 1'b1;
                end
            end

            // Wait for lock; if it never comes, pulse the MMCM reset again.
            ST_WAIT_LOCK: begin
                rst_nxt_s   = RST_ALL;
                ready_nxt_s = 1'b0;
                if (locked_s) begin
                    state_nxt_s    = ST_HOLD;
                    cnt_nxt_s      = CNT_ZERO;
                    mmcm_rst_nxt_s = 1'b0;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s    = ST_MMCM_RST;
                    cnt_nxt_s      = CNT_ZERO;
                    mmcm_rst_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s      = cnt_inc_s;
                    mmcm_rst_nxt_s = 1'b0;
                end
            end

            // Require an unbroken run of locked cycles. A glitch here is not
            // a loss event: nothing has been released yet.
            ST_HOLD: begin
                if (!locked_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == HOLD_LAST) begin
                    cnt_nxt_s    = CNT_ZERO;
                    rst_nxt_s[0] = 1'b0;
                    if (CHANNELS == 1) begin
                        state_nxt_s = ST_RUN;
                        ready_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RELEASE;
                    end
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end

            // Counter measures cycles since channel 0 released; channel k
            // drops once that reaches k*STAGGER. Bits only ever clear here,
            // so release order is always 0, 1, 2, ...
            ST_RELEASE: begin
                if (!locked_s) begin
                    state_nxt_s    = ST_WAIT_LOCK;
                    cnt_nxt_s      = CNT_ZERO;
                    mmcm_rst_nxt_s = 1'b0;
                    rst_nxt_s      = RST_ALL;
                    ready_nxt_s    = 1'b0;
                    loss_evt_s     = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                    for (int k = 1; k < CHANNELS; k++) begin
                        if (cnt_inc_s >= CNT_W'(k * STAGGER)) begin
                            rst_nxt_s[k] = 1'b0;
                        end else begin
                            rst_nxt_s[k] = rst_r[k];
                        end
                    end
                    if (cnt_inc_s == RELEASE_LAST) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_ZERO;
                        ready_nxt_s = 1'b1;
                    end else begin
                        ready_nxt_s = 1'b0;
                    end
                end
            end

            // Steady state; watch for lock loss.
            ST_RUN: begin
                if (!locked_s) begin
                    state_nxt_s    = ST_WAIT_LOCK;
                    cnt_nxt_s      = CNT_ZERO;
                    mmcm_rst_nxt_s = 1'b0;
                    rst_nxt_s      = RST_ALL;
                    ready_nxt_s    = 1'b0;
                    loss_evt_s     = 1'b1;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                    rst_nxt_s   = {CHANNELS{1'b0}};
                    ready_nxt_s = 1'b1;
                end
            end

            // Illegal encoding: restart the whole sequence safely.
            default: begin
                state_nxt_s    = ST_MMCM_RST;
                cnt_nxt_s      = CNT_ZERO;
                mmcm_rst_nxt_s = 1'b1;
                rst_nxt_s      = RST_ALL;
                ready_nxt_s    = 1'b0;
            end
        endcase
    end

    assign o_mmcm_rst = mmcm_rst_r;
    assign o_rst      = rst_r;
    assign o_ready    = ready_r;

`ifdef CORESCORE_RST_LOSS_CNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of lock-loss events seen after release began.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            loss_cnt_r <= 8'd0;
        end else if (loss_evt_s && (loss_cnt_r != 8'd255)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign o_loss_cnt = loss_cnt_r;
`else
    // Without the loss counter the event strobe has no consumer; fold it
    // into a sink so the signal stays visible for debug probing.
    logic loss_evt_unused_s;
    assign loss_evt_unused_s = loss_evt_s;
`endif

endmodule

// File: tb/tb_corescore_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_corescore_rst_seq
// Directed self-checking bench for corescore_rst_seq with default parameters.
// Expected values are hand-derived edge numbers counted from the first clock
// edge after i_rst falls (edge n=1). Outputs are sampled 1 ns after each edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_corescore_rst_seq;

    logic       i_clk;
    logic       i_rst;
    logic       i_locked;
    logic       o_mmcm_rst;
    logic [2:0] o_rst;
    logic       o_ready;
`ifdef CORESCORE_RST_LOSS_CNT_EN
    logic [7:0] o_loss_cnt;
`endif

    int checks;
    int errors;

    corescore_rst_seq #(
        .CHANNELS        (3),
        .SYNC_STAGES     (2),
        .MMCM_RST_CYCLES (8),
        .LOCK_TIMEOUT    (64),
        .HOLD_CYCLES     (16),
        .STAGGER         (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_locked   (i_locked),
        .o_mmcm_rst (o_mmcm_rst),
        .o_rst      (o_rst),
        .o_ready    (o_ready)
`ifdef CORESCORE_RST_LOSS_CNT_EN
        ,
        .o_loss_cnt (o_loss_cnt)
`endif
    );

    // 100 MHz free-running board clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Count one comparison and report it if it disagrees.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Compare {o_mmcm_rst, o_rst, o_ready} against an expected triple.
    task automatic check_outs(input string tag, input int n, input logic mm,
                              input logic [2:0] r, input logic rd);
        check_eq($sformatf("%s n=%0d", tag, n),
                 {27'd0, o_mmcm_rst, o_rst, o_ready},
                 {27'd0, mm, r, rd});
    endtask

    // Nominal power-up with lock held high: MMCM reset edges 1..7, HOLD entered
    // at edge 9, o_rst[0] clears at 25, o_rst[1] at 29, o_rst[2]+ready at 33.
    task automatic run_nominal(input string tag, input int last);
        for (int n = 1; n <= last; n++) begin
            tick();
            check_outs(tag, n, (n < 8), {(n < 33), (n < 29), (n < 25)}, (n >= 33));
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        i_rst    = 1'b1;
        i_locked = 1'b1;

        // ---- Reset state and nominal sequence ------------------------------
        tick();
        tick();
        check_outs("reset", 0, 1'b1, 3'b111, 1'b0);
`ifdef CORESCORE_RST_LOSS_CNT_EN
        check_eq("reset loss_cnt", {24'd0, o_loss_cnt}, 32'd0);
`endif
        i_rst = 1'b0;
        run_nominal("nominal", 40);

        // ---- Lock loss in RUN for 5 cycles ---------------------------------
        // i_locked low for edges 41..45; locked_s low after 42, so resets
        // re-assert at 43. locked_s returns after 47, HOLD from 48, o_rst[0]
        // clears at 64, o_rst[1] at 68, o_rst[2]+ready at 72.
        i_locked = 1'b0;
        for (int n = 41; n <= 75; n++) begin
            tick();
            if (n == 45) begin
                i_locked = 1'b1;
            end
            if (n < 43) begin
                check_outs("loss", n, 1'b0, 3'b000, 1'b1);
            end else begin
                check_outs("loss", n, 1'b0, {(n < 72), (n < 68), (n < 64)}, (n >= 72));
            end
        end
`ifdef CORESCORE_RST_LOSS_CNT_EN
        check_eq("loss loss_cnt", {24'd0, o_loss_cnt}, 32'd1);
`endif

        // ---- One-cycle lock glitch at HOLD count 10 ------------------------
        // i_locked low only for edge 18; FSM sees it at 20 -> WAIT_LOCK,
        // back to HOLD at 21, o_rst[0] clears at 37, [1] at 41, [2] at 45.
        i_rst = 1'b1;
        tick();
        check_outs("glitch reset", 0, 1'b1, 3'b111, 1'b0);
        i_rst = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (n == 17) begin
                i_locked = 1'b0;
            end
            if (n == 18) begin
                i_locked = 1'b1;
            end
            check_outs("glitch", n, (n < 8), {(n < 45), (n < 41), (n < 37)}, (n >= 45));
        end
`ifdef CORESCORE_RST_LOSS_CNT_EN
        check_eq("glitch loss_cnt", {24'd0, o_loss_cnt}, 32'd0);
`endif

        // ---- i_rst mid-release when o_rst=3'b110 ---------------------------
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        run_nominal("pre-midrst", 26);
        i_rst = 1'b1;
        tick();
        check_outs("midrst", 0, 1'b1, 3'b111, 1'b0);
        i_rst = 1'b0;
        run_nominal("replay", 40);

        // ---- Never locked: 8 high / 64 low MMCM reset, period 72 ------------
        i_locked = 1'b0;
        i_rst    = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int n = 1; n <= 160; n++) begin
            tick();
            check_outs("nolock", n, ((n % 72) < 8), 3'b111, 1'b0);
        end

`ifdef CORESCORE_RST_LOSS_CNT_EN
        // ---- 300 loss events: counter saturates at 255 ---------------------
        i_locked = 1'b1;
        i_rst    = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (40) tick();
        check_outs("sat start", 40, 1'b0, 3'b000, 1'b1);
        for (int e = 0; e < 300; e++) begin
            i_locked = 1'b0;
            tick();
            i_locked = 1'b1;
            repeat (40) tick();
        end
        check_eq("sat loss_cnt", {24'd0, o_loss_cnt}, 32'd255);
        i_rst = 1'b1;
        tick();
        check_eq("sat clear", {24'd0, o_loss_cnt}, 32'd0);
        i_rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
